inverter_stim_checker: RTL and testbench
========================================

// Module: inverter_stim_checker
// PURPOSE
//   Self-checking stimulus/response stage wrapped around the switch-level inverter cells (pmos_inverter et al.).
//   Drives a pseudo-random bit stream into the cell under test and waits a settle window.
//   Samples the cell output and compares it with the inverted stimulus.
//   Accumulates error statistics for a regression summary; behavioural checker, simulation-only.
// PARAMETERS
//   NUM_VECTORS    16       vectors applied per run (1..2**CNT_W-1)
//   SETTLE_CYCLES  2        clocks between stimulus change and sample (>=1)
//   CNT_W          8        width of vector/error counters and error index
//   SEED           4'b1001  LFSR seed, reloaded on every start (must be nonzero)
// PORTS
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous, active-high reset
//   start          in   1      begin a run; sampled only in IDLE
//   stim           out  1      bit driven to cell-under-test input
//   dut_out        in   1      cell-under-test output (may be 0/1/X/Z)
//   busy           out  1      high in DRIVE/SETTLE/SAMPLE
//   done           out  1      one-cycle pulse: run complete
//   pass           out  1      1 if last completed run had zero errors
//   err_count      out  CNT_W  mismatches in current/last run, saturating
//   vec_count      out  CNT_W  vectors sampled in current/last run
//   first_err_idx  out  CNT_W  index of first mismatching vector; all-ones if none
// BEHAVIOUR
// - Reset (next edge with rst=1, any state):
//   - state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, first_err_idx=all-ones, lfsr=SEED.
//   - rst asserted mid-run aborts the run with no done pulse.
// - FSM: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
// - IDLE:
//   - On start=1: lfsr<=SEED; err_count, vec_count <= 0; first_err_idx<=all-ones; pass<=0; go DRIVE.
//   - start while not IDLE is ignored.
// - DRIVE (1 cycle): stim<=lfsr[0]; settle counter cleared; go SETTLE.
// - SETTLE: stays SETTLE_CYCLES cycles with stim stable, then goes SAMPLE.
// - SAMPLE (1 cycle):
//   - mismatch = (dut_out !== ~stim); X and Z count as mismatches.
//   - On mismatch: err_count+1, saturating at all-ones; if first_err_idx is all-ones, first_err_idx<=vec_count.
//   - vec_count+1; lfsr <= {lfsr[2:0], lfsr[3]^lfsr[2]}.
//   - If the incremented vec_count == NUM_VECTORS go DONE, else DRIVE.
// - DONE (1 cycle): done=1, busy=0, pass<=(err_count==0); go IDLE.
// - Statistics, pass and stim hold their values in IDLE until the next start or rst.
// - Latency: SETTLE_CYCLES+2 clocks per vector.
//   - done is high in cycle NUM_VECTORS*(SETTLE_CYCLES+2)+1 after the start edge.
// - Stim sequence from SEED=1001: 1,1,0,1,0,1,1,1,1,0,0,0,1,0,0,1 (15-periodic, then repeats).
// - start asserted in the same cycle as the done pulse is ignored; a new run needs start in IDLE.
// TESTING
// 1. Ideal inverter (dut_out = ~stim after 1 clk), start pulse:
//    - done at cycle 65; pass=1, err_count=0, vec_count=16, first_err_idx=8'hFF.
// 2. dut_out stuck at 1:
//    - done at cycle 65; err_count=9, first_err_idx=0, pass=0.
// 3. dut_out stuck at 0:
//    - err_count=7, first_err_idx=2, pass=0.
// 4. dut_out=Z throughout:
//    - err_count=16, first_err_idx=0, pass=0.
// 5. Reset mid-run:
//    - rst=1 at cycle 20 -> next edge busy=0, stim=0, vec_count=0, no done pulse.
//    - A new start then gives the same result as scenario 1.
// 6. Start handling:
//    - start held high for the whole run -> exactly one run.
//    - Second start pulse while busy -> ignored; vec_count=16.
//    - Back-to-back runs give identical stim sequences.

Source files
------------

// File: rtl/inverter_stim_checker.sv
// Stimulus/response checker for an inverter cell: drives an LFSR bit stream,
// samples the cell output after a settle window and accumulates mismatch statistics.
module inverter_stim_checker #(
   parameter int          NUM_VECTORS   = 16,
   parameter int          SETTLE_CYCLES = 2,
   parameter int          CNT_W         = 8,
   parameter logic [3:0]  SEED          = 4'b1001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             stim,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] first_err_idx
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ALL_ONES    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] NUM_LAST    = CNT_W'(NUM_VECTORS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       lfsr;
   logic [SW-1:0]    settle_cnt;
   logic [CNT_W-1:0] vec_inc;
   logic             mismatch;

   // Case inequality so that X or Z on the cell output counts as a failure.
   assign mismatch = (dut_out !== ~stim);
   assign vec_inc  = vec_count + CNT_W'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = DRIVE;
            end else begin
               state_next = IDLE;
            end
         end
         DRIVE:  state_next = SETTLE;
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_next = SAMPLE;
            end else begin
               state_next = SETTLE;
            end
         end
         SAMPLE: begin
            if (vec_inc == NUM_LAST) begin
               state_next = DONE;
            end else begin
               state_next = DRIVE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs; busy/done follow the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         stim          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= {CNT_W{1'b0}};
         vec_count     <= {CNT_W{1'b0}};
         first_err_idx <= ALL_ONES;
         lfsr          <= SEED;
         settle_cnt    <= {SW{1'b0}};
      end else begin
         busy <= (state_next == DRIVE) || (state_next == SETTLE) || (state_next == SAMPLE);
         done <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  lfsr          <= SEED;
                  err_count     <= {CNT_W{1'b0}};
                  vec_count     <= {CNT_W{1'b0}};
                  first_err_idx <= ALL_ONES;
                  pass          <= 1'b0;
               end
            end
            DRIVE: begin
               stim       <= lfsr[0];
               settle_cnt <= {SW{1'b0}};
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + SW'(1);
            end
            SAMPLE: begin
               if (mismatch) begin
                  if (err_count != ALL_ONES) begin
                     err_count <= err_count + CNT_W'(1);
                  end
                  if (first_err_idx == ALL_ONES) begin
                     first_err_idx <= vec_count;
                  end
               end
               vec_count <= vec_inc;
               lfsr      <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            end
            DONE: begin
               pass <= (err_count == {CNT_W{1'b0}});
            end
            default: begin
               stim <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inverter_stim_checker.sv
// Scoreboard bench for inverter_stim_checker: directed runs push expected run
// results; a monitor pops and compares them on every done pulse.
module tb_inverter_stim_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       dut_out;
   logic       stim;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] vec_count;
   logic [7:0] first_err_idx;

   always #5 clk = ~clk;

   inverter_stim_checker dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stim          (stim),
      .dut_out       (dut_out),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .vec_count     (vec_count),
      .first_err_idx (first_err_idx)
   );

   // Cell models: 0 = ideal inverter with one clock delay, 1 = stuck at 1, 2 = stuck at 0.
   int   mode = 0;
   logic inv_r = 1'b1;
   always @(posedge clk) inv_r <= ~stim;
   assign dut_out = (mode == 0) ? inv_r : ((mode == 1) ? 1'b1 : 1'b0);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int err;
      int vec;
      int first;
      int ok;
      int start_cyc;
   } exp_t;

   exp_t q[$];
   int checks   = 0;
   int passes   = 0;
   int done_cnt = 0;
   logic [15:0] stim_tab = 16'b1001_0001_1110_1011;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: each done pulse is matched against the oldest expected run.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
            end else begin
               e = q.pop_front();
               chk("done_latency", cyc - e.start_cyc, 64);
               chk("err_count", int'(err_count), e.err);
               chk("vec_count", int'(vec_count), e.vec);
               chk("first_err_idx", int'(first_err_idx), e.first);
               chk("busy_in_done", int'(busy), 0);
               @(negedge clk);
               chk("done_width", int'(done), 0);
               chk("pass", int'(pass), e.ok);
            end
         end
      end
   end

   task automatic start_run(input int err, input int vec, input int first, input int ok,
                            output int s);
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1;
      s = cyc + 1;
      e.err = err; e.vec = vec; e.first = first; e.ok = ok; e.start_cyc = s;
      q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_cnt < n && t < 400) begin
         @(posedge clk);
         t++;
      end
      if (done_cnt < n) begin
         checks++;
         $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, n);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_capture(input int n);
      int s;
      start_run(0, 16, 255, 1, s);
      for (int v = 0; v < 16; v++) begin
         while (cyc < s + 4 * v + 2) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk($sformatf("stim_run%0d_v%0d", n, v), int'(stim), int'(stim_tab[v]));
      end
      wait_done(n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int s;
      int t;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_stim", int'(stim), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_vec", int'(vec_count), 0);
      chk("rst_first", int'(first_err_idx), 255);
      rst = 1'b0;

      // Ideal inverter, stuck-at-1, stuck-at-0.
      mode = 0; start_run(0, 16, 255, 1, s); wait_done(1);
      mode = 1; start_run(9, 16, 0, 0, s);   wait_done(2);
      mode = 2; start_run(7, 16, 2, 0, s);   wait_done(3);

      // Reset in the middle of a run aborts it without a done pulse.
      mode  = 0;
      @(posedge clk); #1;
      start = 1'b1;
      s     = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < s + 19) begin
         @(posedge clk); #1;
      end
      chk("pre_abort_vec", int'(vec_count), 4);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_stim", int'(stim), 0);
      chk("abort_vec", int'(vec_count), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_first", int'(first_err_idx), 255);
      rst = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      chk("no_done_after_abort", done_cnt, 3);
      start_run(0, 16, 255, 1, s); wait_done(4);

      // Start held high for a whole run: exactly one run.
      @(posedge clk); #1;
      start = 1'b1;
      begin
         exp_t e;
         e.err = 0; e.vec = 16; e.first = 255; e.ok = 1; e.start_cyc = cyc + 1;
         q.push_back(e);
      end
      t = 0;
      while (done_cnt < 5 && t < 400) begin
         @(posedge clk);
         t++;
      end
      #1;
      start = 1'b0;
      if (done_cnt < 5) begin
         checks++;
         $display("FAIL held_start_timeout: got %0d done pulses, expected 5", done_cnt);
      end
      repeat (20) @(posedge clk);
      #1;
      chk("held_start_idle_busy", int'(busy), 0);
      chk("held_start_one_run", done_cnt, 5);

      // A second start while busy is ignored.
      start_run(0, 16, 255, 1, s);
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(6);
      chk("ignored_start_count", done_cnt, 6);

      // Back-to-back runs replay the same stimulus sequence.
      run_capture(7);
      run_capture(8);

      repeat (5) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
